// File: rtl/cache_line_state_array.sv
// Per-line valid/dirty store with flush sequencer for the direct-mapped cache.
// Optional dirty-line counter enabled by defining CACHE_DIRTY_COUNT_EN.
module cache_line_state_array #(
  parameter int INDEX_W   = 10,
  parameter int NUM_LINES = 1 << INDEX_W
) (
  input  logic               globalclock,
  input  logic               reset,
  input  logic               wrEn,
  input  logic [INDEX_W-1:0] address,
  input  logic               inValid,
  input  logic               inDirty,
  output logic               isValid,
  output logic               isDirty,
  input  logic               flushReq,
  output logic               flushBusy,
  output logic               flushDone,
  output logic               wbReq,
  output logic [INDEX_W-1:0] wbIndex,
  input  logic               wbAck,
  output logic [INDEX_W:0]   dirtyCount
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    WB,
    DONE
  } state_t;

  localparam logic [INDEX_W-1:0] LAST = INDEX_W'(NUM_LINES - 1);

  state_t               state;
  logic [INDEX_W-1:0]   ptr;
  logic [NUM_LINES-1:0] valid;
  logic [NUM_LINES-1:0] dirty;
  logic                 wrDirty;
  logic                 wrFire;
  logic                 wbFire;

  assign isValid = valid[address];
  assign isDirty = dirty[address];
  assign wrDirty = inDirty & inValid;
  assign wrFire  = wrEn && (state == IDLE);
  assign wbFire  = wbAck && (state == WB);

  // Line state writes, flush walk and registered handshake outputs.
  always_ff @(posedge globalclock or posedge reset) begin
    if (reset) begin
      valid     <= '0;
      dirty     <= '0;
      state     <= IDLE;
      ptr       <= '0;
      flushBusy <= 1'b0;
      flushDone <= 1'b0;
      wbReq     <= 1'b0;
      wbIndex   <= '0;
    end else begin
      flushDone <= 1'b0;
      unique case (state)
        IDLE: begin
          if (wrFire) begin
            valid[address] <= inValid;
            dirty[address] <= wrDirty;
          end
          if (flushReq) begin
            state     <= SCAN;
            ptr       <= '0;
            flushBusy <= 1'b1;
          end
        end
        SCAN: begin
          if (valid[ptr] && dirty[ptr]) begin
            state   <= WB;
            wbReq   <= 1'b1;
            wbIndex <= ptr;
          end else begin
            valid[ptr] <= 1'b0;
            if (ptr == LAST) begin
              state     <= DONE;
              ptr       <= '0;
              flushDone <= 1'b1;
            end else begin
              ptr <= ptr + 1'b1;
            end
          end
        end
        WB: begin
          if (wbAck) begin
            valid[ptr] <= 1'b0;
            dirty[ptr] <= 1'b0;
            wbReq      <= 1'b0;
            if (ptr == LAST) begin
              state     <= DONE;
              ptr       <= '0;
              flushDone <= 1'b1;
            end else begin
              state <= SCAN;
              ptr   <= ptr + 1'b1;
            end
          end
        end
        DONE: begin
          state     <= IDLE;
          flushBusy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CACHE_DIRTY_COUNT_EN
  logic [INDEX_W:0] cnt;

  // Track dirty 0->1 and 1->0 transitions; only one can occur per cycle.
  always_ff @(posedge globalclock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (wrFire && wrDirty && !dirty[address]) begin
      cnt <= cnt + 1'b1;
    end else if (wrFire && !wrDirty && dirty[address]) begin
      cnt <= cnt - 1'b1;
    end else if (wbFire) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign dirtyCount = cnt;
`else
  assign dirtyCount = '0;
`endif

endmodule

// File: tb/tb_cache_line_state_array.sv
// Randomized bench for cache_line_state_array against a line-level model.
// Model keeps plain bit arrays; flush expectations derive from timing rules.
module tb_cache_line_state_array;

  localparam int IW = 10;
  localparam int NL = 1 << IW;

  logic          globalclock;
  logic          reset;
  logic          wrEn;
  logic [IW-1:0] address;
  logic          inValid;
  logic          inDirty;
  logic          isValid;
  logic          isDirty;
  logic          flushReq;
  logic          flushBusy;
  logic          flushDone;
  logic          wbReq;
  logic [IW-1:0] wbIndex;
  logic          wbAck;
  logic [IW:0]   dirtyCount;

  cache_line_state_array #(.INDEX_W(IW)) dut (
    .globalclock(globalclock),
    .reset(reset),
    .wrEn(wrEn),
    .address(address),
    .inValid(inValid),
    .inDirty(inDirty),
    .isValid(isValid),
    .isDirty(isDirty),
    .flushReq(flushReq),
    .flushBusy(flushBusy),
    .flushDone(flushDone),
    .wbReq(wbReq),
    .wbIndex(wbIndex),
    .wbAck(wbAck),
    .dirtyCount(dirtyCount)
  );

  initial globalclock = 1'b0;
  always #5 globalclock = ~globalclock;

  int checks   = 0;
  int failures = 0;

  bit mv [NL];
  bit md [NL];

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int exp_count();
    int n = 0;
`ifdef CACHE_DIRTY_COUNT_EN
    for (int i = 0; i < NL; i++) n += int'(md[i]);
`endif
    return n;
  endfunction

  task automatic tick();
    @(posedge globalclock);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < NL; i++) begin
      mv[i] = 1'b0;
      md[i] = 1'b0;
    end
  endtask

  task automatic model_write(input int a, input bit v, input bit d);
    mv[a] = v;
    md[a] = v & d;
  endtask

  task automatic write(input int a, input bit v, input bit d);
    wrEn    = 1'b1;
    address = IW'(a);
    inValid = v;
    inDirty = d;
    tick();
    wrEn = 1'b0;
    model_write(a, v, d);
  endtask

  task automatic look(input string tag, input int a);
    address = IW'(a);
    #1;
    check({tag, "_valid"}, isValid, mv[a]);
    check({tag, "_dirty"}, isDirty, md[a]);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #7;
    reset = 1'b0;
    model_clear();
    @(negedge globalclock);
  endtask

  task automatic sweep(input string tag);
    int bad = 0;
    for (int i = 0; i < NL; i++) begin
      address = IW'(i);
      #1;
      if (isValid !== mv[i] || isDirty !== md[i]) bad++;
    end
    check(tag, bad, 0);
  endtask

  task automatic run_flush(input int w, input bit same_wr, input bit disturb);
    int q[$];
    int exp_edges;
    int edges;
    int waits;
    int seen;
    int nwb;
    bit ack_now;
    bit prev_req;
    bit done;
    @(negedge globalclock);
    flushReq = 1'b1;
    if (same_wr) begin
      wrEn    = 1'b1;
      address = '0;
      inValid = 1'b1;
      inDirty = 1'b1;
      model_write(0, 1'b1, 1'b1);
    end
    for (int i = 0; i < NL; i++)
      if (mv[i] && md[i]) q.push_back(i);
    nwb       = q.size();
    exp_edges = NL + 1 + nwb * (1 + w);
    tick();
    flushReq = 1'b0;
    wrEn     = 1'b0;
    edges    = 1;
    check("busy_start", flushBusy, 1);
    waits    = 0;
    seen     = 0;
    prev_req = 1'b0;
    done     = 1'b0;
    while (!done && edges < 8000) begin
      if (disturb && edges == 5) begin
        wrEn     = 1'b1;
        address  = IW'(10);
        inValid  = 1'b1;
        inDirty  = 1'b1;
        flushReq = 1'b1;
      end else begin
        wrEn     = 1'b0;
        flushReq = 1'b0;
      end
      ack_now = wbReq && (waits == w);
      wbAck   = ack_now;
      tick();
      edges++;
      wbAck = 1'b0;
      if (disturb && edges == 6) begin
        wrEn     = 1'b0;
        flushReq = 1'b0;
        address  = IW'(10);
        #1;
        check("wr_blocked", isValid, mv[10]);
      end
      if (ack_now) begin
        check("wbreq_drop", wbReq, 0);
        if (q.size() > 0) void'(q.pop_front());
        waits = 0;
      end else if (wbReq && prev_req) begin
        waits++;
      end
      if (wbReq && !prev_req) seen++;
      if (wbReq) begin
        if (q.size() == 0) check("wb_extra", wbIndex, -1);
        else if (wbIndex !== IW'(q[0])) check("wb_index", wbIndex, q[0]);
      end
      prev_req = wbReq;
      if (flushDone) done = 1'b1;
    end
    check("flush_edges", edges, exp_edges);
    check("wb_count", seen, nwb);
    check("busy_done", flushBusy, 1);
    tick();
    check("done_pulse", flushDone, 0);
    check("busy_end", flushBusy, 0);
    model_clear();
    sweep("flush_clear");
    check("cnt_flush", dirtyCount, exp_count());
  endtask

  initial begin
    reset    = 1'b1;
    wrEn     = 1'b0;
    address  = '0;
    inValid  = 1'b0;
    inDirty  = 1'b0;
    flushReq = 1'b0;
    wbAck    = 1'b0;
    model_clear();
    #12;
    check("rst_busy", flushBusy, 0);
    check("rst_wbreq", wbReq, 0);
    check("rst_wbidx", wbIndex, 0);
    check("rst_cnt", dirtyCount, 0);
    check("rst_done", flushDone, 0);
    reset = 1'b0;
    @(negedge globalclock);
    look("rst0", 0);
    look("rst5", 5);
    look("rst1023", 1023);

    write(5, 1'b1, 1'b1);
    look("w5", 5);
    write(7, 1'b0, 1'b1);
    look("w7", 7);

    for (int n = 0; n < 200; n++) begin
      int a;
      bit v;
      bit d;
      a = int'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) a = int'($urandom_range(0, NL - 1));
      v = 1'($urandom);
      d = 1'($urandom);
      if ($urandom_range(0, 4) == 0) begin
        address = IW'(a);
        inValid = v;
        inDirty = d;
        tick();
      end else begin
        write(a, v, d);
      end
      look("rnd", a);
      check("rnd_cnt", dirtyCount, exp_count());
    end

    do_reset();
    write(3, 1'b1, 1'b0);
    write(400, 1'b1, 1'b0);
    write(1023, 1'b1, 1'b0);
    run_flush(4, 1'b0, 1'b0);

    write(2, 1'b1, 1'b1);
    write(900, 1'b1, 1'b1);
    write(50, 1'b1, 1'b0);
    check("cnt_two", dirtyCount, exp_count());
    run_flush(4, 1'b0, 1'b1);

    write(1, 1'b1, 1'b1);
    write(77, 1'b1, 1'b1);
    write(1023, 1'b1, 1'b1);
    check("cnt_three", dirtyCount, exp_count());
    write(77, 1'b1, 1'b0);
    check("cnt_clean", dirtyCount, exp_count());
    for (int n = 0; n < 6; n++)
      write(int'($urandom_range(0, NL - 1)), 1'b1, 1'($urandom));
    run_flush(int'($urandom_range(0, 3)), 1'b1, 1'b0);

    write(20, 1'b1, 1'b1);
    write(600, 1'b1, 1'b0);
    @(negedge globalclock);
    flushReq = 1'b1;
    tick();
    flushReq = 1'b0;
    repeat (30) tick();
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_busy", flushBusy, 0);
    check("mid_rst_wbreq", wbReq, 0);
    check("mid_rst_cnt", dirtyCount, 0);
    address = IW'(600);
    #1;
    check("mid_rst_valid", isValid, 0);
    reset = 1'b0;
    model_clear();
    @(negedge globalclock);
    sweep("mid_rst_clear");
    tick();
    check("idle_after_rst", flushBusy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
